mbs_mem_arbiter: RTL and testbench
==================================

Name: mbs_mem_arbiter

Overview:
- Arbitrates the single-port unified memory between three requesters: instruction fetch (0), data load/store (1) and debug/loader port (2).
- Sits between the multicycle core's IF/WB sequencing and the memory model.
- Serialises one transaction at a time using round-robin priority and a variable-latency memory handshake.

Parameters:
DATA_WIDTH, 32, memory data width
ADDR_WIDTH, 32, memory address width
TIMEOUT_CYC, 16, max cycles waiting for mem_ack (used only with the optional feature; must be >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req  input  3  per-requester request; bit i = requester i
we  input  3  per-requester write enable (bit 0 ignored, fetch is read-only)
addr  input  3*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  input  3*DATA_WIDTH  packed write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  3  one-hot current owner, 0 when idle
ack  output  3  one-hot, one-cycle completion pulse to the owner
rdata  output  DATA_WIDTH  read data, valid with ack, held until the next read completes
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, sampled on clk rising edge
err  output  1  one-cycle timeout pulse (optional feature)
busy  output  1  high in any state other than IDLE
state  output  2  current FSM state, for debug

Behaviour:
- All outputs are registered. On reset: state=IDLE, gnt=0, ack=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, round-robin pointer=0. Reset mid-transaction drops mem_req immediately and discards the transaction; no ack is issued.
- FSM encoding: IDLE=0, BUSY=1, DONE=2, REL=3.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit starting at the pointer, scanning upward modulo 3.
  - Next edge: gnt=winner; mem_req=1; mem_we/mem_addr/mem_wdata latched from the winner's slice (mem_we forced 0 for requester 0); state=BUSY.
  - If no req is set, stay in IDLE.
- BUSY:
  - mem_req and the latched address/data stay stable.
  - On mem_ack=1: mem_req=0, mem_we=0; ack[owner]=1 for exactly one cycle. If the access was a read, rdata<=mem_rdata (a write leaves rdata unchanged). pointer<=(owner+1) mod 3; state=DONE.
- DONE: ack is cleared and gnt cleared; state=REL.
- REL: one dead cycle so the requester can drop req; no grant is made; state=IDLE.
- Latency, with a request first seen in IDLE at edge 0 and memory acking in its first BUSY cycle: mem_req high after edge 0, ack high after edge 1. Minimum spacing between grants is 4 cycles.
- Requesters hold req/we/addr/wdata until ack. A req that drops during BUSY is ignored; the transaction completes and ack still pulses.
- mem_ack outside BUSY is ignored.
- Simultaneous requests are resolved by round-robin only. No requester can be starved while others keep requesting.
- gnt changes only on IDLE->BUSY and DONE->REL.

Optional Feature:
- Macro MBS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYC-1 with mem_ack still low: mem_req=0; ack[owner] and err pulse for one cycle; rdata<=0 if the access was a read; pointer advances; state=DONE.
  - A mem_ack arriving on that same edge wins, and err stays 0.
- Not defined: no counter; BUSY waits indefinitely for mem_ack; err is tied to 0.

Test Plan:
- Single fetch read: req=3'b001, addr0=0x100, memory acks on the 2nd BUSY cycle with 0x1234_5678 -> mem_addr=0x100, mem_we=0, ack=3'b001 for one cycle, rdata=0x1234_5678, busy low 2 cycles after ack.
- Data write: req=3'b010, we=3'b010, addr1=0x200, wdata1=0xCAFE_F00D -> mem_we=1 with that data; ack=3'b010; rdata keeps its previous value.
- Round-robin: all three req held continuously, with 1-cycle memory -> grant order 0,1,2,0,1,2, each grant 4 cycles apart.
- Fetch with we[0]=1, addr0=0x40 -> mem_we stays 0; the access is treated as a read.
- Reset asserted while in BUSY with mem_req=1 -> mem_req=0 and state=0 immediately; no ack; after release, req=3'b100 is granted as the first (pointer=0 scan).
- With MBS_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=4: mem_ack never asserted on a read from requester 1 -> mem_req drops after 4 BUSY cycles; err=1 and ack=3'b010 for one cycle; rdata=0.

Source files
------------

// File: rtl/mbs_mem_arbiter.sv
// Round-robin arbiter serialising fetch/data/debug requesters onto one memory port.
// Define MBS_ARB_TIMEOUT_EN to abort transactions whose mem_ack never arrives.
module mbs_mem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    err,
  output logic                    busy,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_REL  = 2'd3
  } state_e;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cyc
    $error("mbs_mem_arbiter: TIMEOUT_CYC must be >= 2");
  end

  state_e                state_q, state_d;
  logic [2:0]            gnt_q, gnt_d;
  logic [2:0]            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            owner_q, owner_d;

  logic                  win_found;
  logic [1:0]            win_idx;

`ifdef MBS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

  // First set request at or above the pointer, wrapping modulo 3.
  always_comb begin : p_pick
    logic [2:0] k3;
    logic [1:0] k;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      k3 = {1'b0, ptr_q} + 3'(i);
      if (k3 >= 3'd3) k3 = k3 - 3'd3;
      k = k3[1:0];
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_idx   = k;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
`ifdef MBS_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_BUSY;
          gnt_d       = 3'b001 << win_idx;
          owner_d     = win_idx;
          mem_req_d   = 1'b1;
          mem_we_d    = we[win_idx] & (win_idx != 2'd0);
          mem_addr_d  = addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef MBS_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ack_d     = gnt_q;
          ptr_d     = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          if (!mem_we_q) rdata_d = mem_rdata;
        end
`ifdef MBS_ARB_TIMEOUT_EN
        // An ack on the expiry edge takes the normal path above.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ack_d     = gnt_q;
          err_d     = 1'b1;
          ptr_d     = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          if (!mem_we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_REL;
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
`ifdef MBS_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
`ifdef MBS_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mbs_mem_arbiter.sv
// Directed bench for mbs_mem_arbiter: scoreboard of expected completions, a
// variable-latency memory model, and checks on grant order and timing.
module tb_mbs_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, ack;
  logic [DW-1:0]   rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = 32'hDEAD_BEEF;
  logic            mem_ack = 1'b0;
  logic            err, busy;
  logic [1:0]      state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int bcnt = 0;

  typedef struct {
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  logic [DW-1:0] last_rd = '0;

  mbs_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .err(err), .busy(busy), .state(state)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
  endfunction

  task automatic expect_txn(input int unsigned idx, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic to);
    exp_t e;
    e.ack = 3'b001 << idx;
    e.we = w; e.addr = a; e.wdata = d; e.err = to;
    if (to) begin
      if (!w) last_rd = '0;
    end else if (!w) begin
      last_rd = mem_rd(a);
    end
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic drive(input int unsigned idx, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    addr[idx*AW +: AW]  = a;
    wdata[idx*DW +: DW] = d;
    we[idx]  = w;
    req[idx] = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (ack === 3'b000 && n < 60) begin @(negedge clk); n++; end
    if (ack === 3'b000) begin
      checks++; failures++;
      $error("FAIL %s: observed=no ack expected=ack within 60 cycles", tag);
    end
  endtask

  // Memory model: acks in BUSY cycle 'lat' (0 = never), checks the request it sees.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      bcnt = 0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    end else if (!mem_ack) begin
      bcnt++;
      if (bcnt == 1) begin
        if (sb.size() == 0) chk("mem_req_unexpected", 32'(mem_req), 32'd0);
        else begin
          chk("mem_we", 32'(mem_we), 32'(sb[0].we));
          chk("mem_addr", mem_addr, sb[0].addr);
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (lat != 0 && bcnt == lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Completion monitor: every ack pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack !== 3'b000) begin
      if (sb.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("rdata", rdata, e.rdata);
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_cyc;
    int n;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; lat = 1;
    mem[32'h100] = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch read, memory acks in the second BUSY cycle.
    lat = 2;
    drive(0, 1'b0, 32'h100, '0);
    expect_txn(0, 1'b0, 32'h100, '0, 1'b0);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_state_busy", 32'(state), 32'd1);
    wait_ack("t1_ack_wait");
    req = '0;
    chk("t1_state_done", 32'(state), 32'd2);
    @(negedge clk);
    chk("t1_state_rel", 32'(state), 32'd3);
    chk("t1_gnt_clr", 32'(gnt), 32'd0);
    chk("t1_busy_rel", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Data write with single-cycle memory: ack one cycle after mem_req.
    lat = 1;
    drive(1, 1'b1, 32'h200, 32'hCAFE_F00D);
    expect_txn(1, 1'b1, 32'h200, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'd2);
    chk("t2_ack_not_yet", 32'(ack), 32'd0);
    @(negedge clk);
    chk("t2_ack_latency", 32'(ack), 32'd2);
    chk("t2_mem_req_drop", 32'(mem_req), 32'd0);
    req = '0; we = '0;
    repeat (2) @(negedge clk);

    // Reset during BUSY; pointer (now 2) must return to 0.
    lat = 0;
    drive(0, 1'b0, 32'h300, '0);
    expect_txn(0, 1'b0, 32'h300, '0, 1'b0);
    @(negedge clk);
    chk("t3_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t3_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t3_rst_state", 32'(state), 32'd0);
    chk("t3_rst_gnt", 32'(gnt), 32'd0);
    sb.delete();
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t3_no_ack", 32'(ack), 32'd0);
    lat = 1;
    drive(0, 1'b0, 32'h304, '0);
    drive(2, 1'b0, 32'h308, '0);
    expect_txn(0, 1'b0, 32'h304, '0, 1'b0);
    @(negedge clk);
    chk("t3_ptr_reset_gnt", 32'(gnt), 32'd1);
    wait_ack("t3_ack_wait");
    req = '0;
    repeat (2) @(negedge clk);

    // Fetch with we[0]=1 is still a read.
    drive(0, 1'b1, 32'h40, 32'h0000_0BAD);
    expect_txn(0, 1'b0, 32'h40, 32'h0000_0BAD, 1'b0);
    wait_ack("t4_ack_wait");
    req = '0; we = '0;
    repeat (2) @(negedge clk);

    // Debug port alone: leaves pointer at 0.
    drive(2, 1'b0, 32'h500, '0);
    expect_txn(2, 1'b0, 32'h500, '0, 1'b0);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'd4);
    wait_ack("t5_ack_wait");
    req = '0;
    repeat (2) @(negedge clk);

    // All three requesting continuously: 0,1,2,0,1,2 four cycles apart.
    for (int k = 0; k < 6; k++)
      expect_txn(k % 3, 1'b0, 32'h600 + 32'(4 * (k % 3)), '0, 1'b0);
    drive(0, 1'b0, 32'h600, '0);
    drive(1, 1'b0, 32'h604, '0);
    drive(2, 1'b0, 32'h608, '0);
    prev_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (gnt === 3'b000 && n < 60) begin @(negedge clk); n++; end
      chk("rr_gnt", 32'(gnt), 32'(3'b001 << (k % 3)));
      if (k > 0) chk("rr_spacing", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc = cyc;
      if (k == 5) req = '0;
      n = 0;
      while (gnt !== 3'b000 && n < 60) begin @(negedge clk); n++; end
    end
    @(negedge clk);

`ifdef MBS_ARB_TIMEOUT_EN
    // Memory never acks: abort after TIMEOUT_CYC BUSY cycles.
    lat = 0;
    drive(1, 1'b0, 32'h700, '0);
    expect_txn(1, 1'b0, 32'h700, '0, 1'b1);
    @(negedge clk);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
    chk("to_busy_cycles", 32'(n), 32'd4);
    chk("to_state_done", 32'(state), 32'd2);
    req = '0;
    repeat (2) @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
